// File: rtl/onehot_regbank_pkg.sv
// regbank_pkg: shared sizes and clear-FSM state type for the one-hot register bank
package regbank_pkg;
  localparam int NREG = 8;
  localparam int IDX_W = 3;
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_e;
endpackage

// File: rtl/onehot_regbank_if.sv
// onehot_regbank_if: write/read/clear/status bus of the register bank
// master drives write select, data, read addresses, clr_req, err_clr; slave returns read data and status flags
interface onehot_regbank_if #(parameter int WIDTH = 32);
  import regbank_pkg::*;
  logic [NREG-1:0] we_onehot;
  logic [WIDTH-1:0] wdata;
  logic [IDX_W-1:0] ra0;
  logic [IDX_W-1:0] ra1;
  logic [WIDTH-1:0] rd0;
  logic [WIDTH-1:0] rd1;
  logic clr_req;
  logic busy;
  logic clr_done;
  logic wr_drop;
  logic err;
  logic err_clr;
  modport master (
    output we_onehot, wdata, ra0, ra1, clr_req, err_clr,
    input  rd0, rd1, busy, clr_done, wr_drop, err
  );
  modport slave (
    input  we_onehot, wdata, ra0, ra1, clr_req, err_clr,
    output rd0, rd1, busy, clr_done, wr_drop, err
  );
endinterface

// File: rtl/onehot_regbank_onehot_to_idx.sv
// onehot_to_idx: one-hot write select to index, with exactly-one and more-than-one flags
// onehot_i: select word; idx_o: index of set bit; valid_o: exactly one bit set; multi_o: two or more bits set
module onehot_to_idx import regbank_pkg::*; (
  input  logic [NREG-1:0]  onehot_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o,
  output logic             multi_o
);
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < NREG; i++) idx_o = idx_o | (onehot_i[i] ? IDX_W'(i) : '0);
  end
  // clearing the lowest set bit leaves something only when two or more bits were set
  assign multi_o = |(onehot_i & (onehot_i - NREG'(1)));
  assign valid_o = |onehot_i & ~multi_o;
endmodule

// File: rtl/onehot_regbank.sv
// onehot_regbank: 8-entry register bank written by one-hot select, two async read ports, bulk clear, illegal-select flag
// clk, rst_n (sync, active-low); bus: slave side of onehot_regbank_if (we_onehot, wdata, ra0/ra1 -> rd0/rd1, clr_req -> busy/clr_done, wr_drop, err/err_clr)
module onehot_regbank import regbank_pkg::*; #(
  parameter int WIDTH    = 32,
  parameter bit ZERO_REG = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  onehot_regbank_if.slave   bus
);
  logic [WIDTH-1:0] regs_q [NREG];
  clr_state_e state_q;
  logic [IDX_W-1:0] cnt_q, idx;
  logic valid, multi, busy, wr_en, wr_drop_q, wr_drop_d, err_q, err_d;
  onehot_to_idx u_dec (.onehot_i(bus.we_onehot), .idx_o(idx), .valid_o(valid), .multi_o(multi));
  assign busy = state_q == CLEAR;
  assign wr_en = valid && !busy && !(ZERO_REG && idx == '0);
  // a zero-register write is silently ignored, so it never counts as dropped
  assign wr_drop_d = multi | (busy & |bus.we_onehot);
  // a new multi-hot event outranks err_clr
  assign err_d = multi | (err_q & ~bus.err_clr);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_drop_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (wr_en) regs_q[idx] <= bus.wdata;
      if (busy) regs_q[cnt_q] <= '0;
      state_q   <= state_q == IDLE  ? (bus.clr_req ? CLEAR : IDLE) :
                   state_q == CLEAR ? (cnt_q == IDX_W'(NREG - 1) ? DONE : CLEAR) : IDLE;
      // held at 0 outside CLEAR so each sweep starts at entry 0; wraps to 0 after the last entry
      cnt_q     <= busy ? cnt_q + IDX_W'(1) : '0;
      wr_drop_q <= wr_drop_d;
      err_q     <= err_d;
    end
  end
  assign bus.rd0      = (ZERO_REG && bus.ra0 == '0) ? '0 : regs_q[bus.ra0];
  assign bus.rd1      = (ZERO_REG && bus.ra1 == '0) ? '0 : regs_q[bus.ra1];
  assign bus.busy     = busy;
  assign bus.clr_done = state_q == DONE;
  assign bus.wr_drop  = wr_drop_q;
  assign bus.err      = err_q;
endmodule
